// File: rtl/disp_cpl_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_cpl_arbiter_pkg
// Brief    : Shared state encodings, requester indices and map constants.
// Revision : 1.0
// ============================================================================
package disp_cpl_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REJ  = 2'd2
    } chanState_t;

    localparam logic        C_R0 = 1'b0;
    localparam logic        C_R1 = 1'b1;

    localparam logic [31:0] C_ADDR_LIMIT = 32'h0000_5000;
    localparam logic [31:0] C_ERR_DATA   = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/disp_cpl_chan_arb.sv
`default_nettype none
// ============================================================================
// Module   : disp_cpl_chan_arb
// Brief    : One CPL channel: two-way round-robin grant with local reject path.
// Revision : 1.0
// ============================================================================
module disp_cpl_chan_arb
    import disp_cpl_arbiter_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = C_ADDR_LIMIT
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iReq0Valid,
    input  logic [31:0] iReq0Address,
    input  logic        iReq1Valid,
    input  logic [31:0] iReq1Address,
    output logic        oCplValid,
    output logic [31:0] oCplAddress,
    input  logic        iCplAck,
    output logic        oReq0Ack,
    output logic        oReq1Ack,
    output chanState_t  oState,
    output logic        oGrant,
    output logic        oRejEnter,
    output logic [31:0] oRejAddress,
    output logic        oRejRequester
);

    chanState_t  r_state;
    chanState_t  w_nextState;
    logic        r_grant;
    logic        w_nextGrant;
    logic        r_ptr;
    logic        w_nextPtr;
    logic        w_selReq;
    logic [31:0] w_selAddress;
    logic        w_selLegal;
    logic        w_anyValid;
    logic [31:0] w_grantAddress;
    logic        w_active;
    logic        w_ackNow;

    assign w_anyValid = iReq0Valid | iReq1Valid;

    // Contention resolves through the pointer; a lone requester wins outright.
    always_comb begin
        w_selReq = C_R0;
        if (iReq0Valid && iReq1Valid) begin
            w_selReq = r_ptr;
        end else if (iReq1Valid) begin
            w_selReq = C_R1;
        end
    end

    assign w_selAddress   = (w_selReq == C_R1) ? iReq1Address : iReq0Address;
    assign w_selLegal     = (w_selAddress < ADDR_LIMIT);
    assign w_grantAddress = (r_grant == C_R1) ? iReq1Address : iReq0Address;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state <= ST_IDLE;
            r_grant <= C_R0;
            r_ptr   <= C_R0;
        end else begin
            r_state <= w_nextState;
            r_grant <= w_nextGrant;
            r_ptr   <= w_nextPtr;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextGrant = r_grant;
        w_nextPtr   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_anyValid) begin
                    w_nextGrant = w_selReq;
                    w_nextState = w_selLegal ? ST_FWD : ST_REJ;
                end
            end
            ST_FWD: begin
                if (iCplAck) begin
                    w_nextState = ST_IDLE;
                    w_nextPtr   = ~r_grant;
                end
            end
            ST_REJ: begin
                w_nextState = ST_IDLE;
                w_nextPtr   = ~r_grant;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Outputs are gated by reset so an aborted transfer never completes.
    assign w_active    = ~iReset;
    assign w_ackNow    = w_active & (((r_state == ST_FWD) & iCplAck) | (r_state == ST_REJ));

    assign oCplValid   = w_active & (r_state == ST_FWD);
    assign oCplAddress = oCplValid ? w_grantAddress : 32'h0;
    assign oReq0Ack    = w_ackNow & (r_grant == C_R0);
    assign oReq1Ack    = w_ackNow & (r_grant == C_R1);
    assign oState      = r_state;
    assign oGrant      = r_grant;

    assign oRejEnter     = w_active & (r_state == ST_IDLE) & w_anyValid & ~w_selLegal;
    assign oRejAddress   = w_selAddress;
    assign oRejRequester = w_selReq;

endmodule
`default_nettype wire

// File: rtl/disp_cpl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : disp_cpl_arbiter
// Brief    : Host-bridge / dispatch-core arbiter for the CPL register port.
// Revision : 1.0
// ============================================================================
module disp_cpl_arbiter
    import disp_cpl_arbiter_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = C_ADDR_LIMIT,
    parameter logic [31:0] ERR_DATA   = C_ERR_DATA
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [31:0] iR0WriteAddress,
    input  logic [31:0] iR0WriteData,
    input  logic        iR0WriteValid,
    output logic        oR0WriteAck,
    input  logic [31:0] iR1WriteAddress,
    input  logic [31:0] iR1WriteData,
    input  logic        iR1WriteValid,
    output logic        oR1WriteAck,
    input  logic [31:0] iR0ReadAddress,
    output logic [31:0] oR0ReadData,
    input  logic        iR0ReadValid,
    output logic        oR0ReadAck,
    input  logic [31:0] iR1ReadAddress,
    output logic [31:0] oR1ReadData,
    input  logic        iR1ReadValid,
    output logic        oR1ReadAck,
    output logic [31:0] oCPLWriteAddress,
    output logic [31:0] oCPLWriteData,
    output logic        oCPLWriteValid,
    input  logic        iCPLWriteAck,
    output logic [31:0] oCPLReadAddress,
    input  logic [31:0] iCPLReadData,
    output logic        oCPLReadValid,
    input  logic        iCPLReadAck,
    output logic        oErrValid,
    output logic [31:0] oErrAddress,
    output logic        oErrIsRead,
    output logic        oErrRequester,
    input  logic        iErrClear
);

    chanState_t  w_wrState;
    logic        w_wrGrant;
    logic        w_wrRejEnter;
    logic [31:0] w_wrRejAddress;
    logic        w_wrRejRequester;
    chanState_t  w_rdState;
    logic        w_rdGrant;
    logic        w_rdRejEnter;
    logic [31:0] w_rdRejAddress;
    logic        w_rdRejRequester;
    logic        w_rdFwd;
    logic        w_rdRej;
    logic [31:0] w_rdRespData;
    logic        w_errTake;

    logic        r_errValid;
    logic [31:0] r_errAddress;
    logic        r_errIsRead;
    logic        r_errRequester;

    disp_cpl_chan_arb #(
        .ADDR_LIMIT (ADDR_LIMIT)
    ) u_wrChan (
        .iClock        (iClock),
        .iReset        (iReset),
        .iReq0Valid    (iR0WriteValid),
        .iReq0Address  (iR0WriteAddress),
        .iReq1Valid    (iR1WriteValid),
        .iReq1Address  (iR1WriteAddress),
        .oCplValid     (oCPLWriteValid),
        .oCplAddress   (oCPLWriteAddress),
        .iCplAck       (iCPLWriteAck),
        .oReq0Ack      (oR0WriteAck),
        .oReq1Ack      (oR1WriteAck),
        .oState        (w_wrState),
        .oGrant        (w_wrGrant),
        .oRejEnter     (w_wrRejEnter),
        .oRejAddress   (w_wrRejAddress),
        .oRejRequester (w_wrRejRequester)
    );

    disp_cpl_chan_arb #(
        .ADDR_LIMIT (ADDR_LIMIT)
    ) u_rdChan (
        .iClock        (iClock),
        .iReset        (iReset),
        .iReq0Valid    (iR0ReadValid),
        .iReq0Address  (iR0ReadAddress),
        .iReq1Valid    (iR1ReadValid),
        .iReq1Address  (iR1ReadAddress),
        .oCplValid     (oCPLReadValid),
        .oCplAddress   (oCPLReadAddress),
        .iCplAck       (iCPLReadAck),
        .oReq0Ack      (oR0ReadAck),
        .oReq1Ack      (oR1ReadAck),
        .oState        (w_rdState),
        .oGrant        (w_rdGrant),
        .oRejEnter     (w_rdRejEnter),
        .oRejAddress   (w_rdRejAddress),
        .oRejRequester (w_rdRejRequester)
    );

    assign oCPLWriteData = (~iReset && (w_wrState == ST_FWD))
                         ? ((w_wrGrant == C_R1) ? iR1WriteData : iR0WriteData)
                         : 32'h0;

    assign w_rdFwd      = ~iReset & (w_rdState == ST_FWD);
    assign w_rdRej      = ~iReset & (w_rdState == ST_REJ);
    assign w_rdRespData = w_rdFwd ? iCPLReadData : (w_rdRej ? ERR_DATA : 32'h0);
    assign oR0ReadData  = (w_rdGrant == C_R0) ? w_rdRespData : 32'h0;
    assign oR1ReadData  = (w_rdGrant == C_R1) ? w_rdRespData : 32'h0;

    // A clear in the same cycle as a new reject makes room for that reject.
    assign w_errTake = (w_wrRejEnter | w_rdRejEnter) & (~r_errValid | iErrClear);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_errValid     <= 1'b0;
            r_errAddress   <= 32'h0;
            r_errIsRead    <= 1'b0;
            r_errRequester <= 1'b0;
        end else if (w_errTake) begin
            r_errValid     <= 1'b1;
            r_errAddress   <= w_wrRejEnter ? w_wrRejAddress : w_rdRejAddress;
            r_errIsRead    <= ~w_wrRejEnter;
            r_errRequester <= w_wrRejEnter ? w_wrRejRequester : w_rdRejRequester;
        end else if (iErrClear) begin
            r_errValid     <= 1'b0;
            r_errAddress   <= 32'h0;
            r_errIsRead    <= 1'b0;
            r_errRequester <= 1'b0;
        end
    end

    assign oErrValid     = r_errValid;
    assign oErrAddress   = r_errAddress;
    assign oErrIsRead    = r_errIsRead;
    assign oErrRequester = r_errRequester;

endmodule
`default_nettype wire

// File: tb/tb_disp_cpl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_cpl_arbiter
// Brief    : Directed self-checking bench for disp_cpl_arbiter.
// Revision : 1.0
// ============================================================================
module tb_disp_cpl_arbiter;

    logic        iClock;
    logic        iReset;
    logic [31:0] iR0WriteAddress, iR0WriteData, iR1WriteAddress, iR1WriteData;
    logic        iR0WriteValid, iR1WriteValid, oR0WriteAck, oR1WriteAck;
    logic [31:0] iR0ReadAddress, iR1ReadAddress, oR0ReadData, oR1ReadData;
    logic        iR0ReadValid, iR1ReadValid, oR0ReadAck, oR1ReadAck;
    logic [31:0] oCPLWriteAddress, oCPLWriteData, oCPLReadAddress, iCPLReadData;
    logic        oCPLWriteValid, iCPLWriteAck, oCPLReadValid, iCPLReadAck;
    logic        oErrValid, oErrIsRead, oErrRequester, iErrClear;
    logic [31:0] oErrAddress;

    int compared   = 0;
    int mismatched = 0;

    disp_cpl_arbiter u_dut (
        .iClock           (iClock),
        .iReset           (iReset),
        .iR0WriteAddress  (iR0WriteAddress),
        .iR0WriteData     (iR0WriteData),
        .iR0WriteValid    (iR0WriteValid),
        .oR0WriteAck      (oR0WriteAck),
        .iR1WriteAddress  (iR1WriteAddress),
        .iR1WriteData     (iR1WriteData),
        .iR1WriteValid    (iR1WriteValid),
        .oR1WriteAck      (oR1WriteAck),
        .iR0ReadAddress   (iR0ReadAddress),
        .oR0ReadData      (oR0ReadData),
        .iR0ReadValid     (iR0ReadValid),
        .oR0ReadAck       (oR0ReadAck),
        .iR1ReadAddress   (iR1ReadAddress),
        .oR1ReadData      (oR1ReadData),
        .iR1ReadValid     (iR1ReadValid),
        .oR1ReadAck       (oR1ReadAck),
        .oCPLWriteAddress (oCPLWriteAddress),
        .oCPLWriteData    (oCPLWriteData),
        .oCPLWriteValid   (oCPLWriteValid),
        .iCPLWriteAck     (iCPLWriteAck),
        .oCPLReadAddress  (oCPLReadAddress),
        .iCPLReadData     (iCPLReadData),
        .oCPLReadValid    (oCPLReadValid),
        .iCPLReadAck      (iCPLReadAck),
        .oErrValid        (oErrValid),
        .oErrAddress      (oErrAddress),
        .oErrIsRead       (oErrIsRead),
        .oErrRequester    (oErrRequester),
        .iErrClear        (iErrClear)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        if (obs !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    logic [1:0]  expGrant;
    logic [31:0] expAddr, expData;
    int          nW, nR;
    logic        upd0, upd1, wAcked, rAcked;

    initial begin
        iReset = 1'b1;
        iR0WriteAddress = '0; iR0WriteData = '0; iR0WriteValid = 1'b0;
        iR1WriteAddress = '0; iR1WriteData = '0; iR1WriteValid = 1'b0;
        iR0ReadAddress = '0; iR0ReadValid = 1'b0;
        iR1ReadAddress = '0; iR1ReadValid = 1'b0;
        iCPLWriteAck = 1'b0; iCPLReadAck = 1'b0; iCPLReadData = '0;
        iErrClear = 1'b0;
        step(); step();

        // Reset state
        checkVal("rst_wr_valid", oCPLWriteValid, 0);
        checkVal("rst_rd_valid", oCPLReadValid, 0);
        checkVal("rst_wr_addr",  oCPLWriteAddress, 0);
        checkVal("rst_acks",     {oR0WriteAck, oR1WriteAck, oR0ReadAck, oR1ReadAck}, 0);
        checkVal("rst_rd_data",  oR0ReadData | oR1ReadData, 0);
        checkVal("rst_err",      {oErrValid, oErrIsRead, oErrRequester}, 0);
        checkVal("rst_err_addr", oErrAddress, 0);
        iReset = 1'b0;
        step();

        // Legal R0 write, decoder acks three cycles after valid
        iR0WriteAddress = 32'h0000_1004; iR0WriteData = 32'h1234_5678; iR0WriteValid = 1'b1;
        #1;
        checkVal("wr_valid_early", oCPLWriteValid, 0);
        step();
        checkVal("wr_valid", oCPLWriteValid, 1);
        checkVal("wr_addr",  oCPLWriteAddress, 32'h0000_1004);
        checkVal("wr_data",  oCPLWriteData, 32'h1234_5678);
        checkVal("wr_noack", {oR0WriteAck, oR1WriteAck}, 0);
        step(); step(); step();
        checkVal("wr_hold_valid", oCPLWriteValid, 1);
        iCPLWriteAck = 1'b1;
        #1;
        checkVal("wr_ack_r0", oR0WriteAck, 1);
        checkVal("wr_ack_r1", oR1WriteAck, 0);
        step();
        iCPLWriteAck = 1'b0; iR0WriteValid = 1'b0;
        #1;
        checkVal("wr_idle_valid", oCPLWriteValid, 0);
        checkVal("wr_idle_ack",   oR0WriteAck, 0);

        // Simultaneous reads: R0 first, idle cycle, then R1
        iR0ReadAddress = 32'h0000_0010; iR1ReadAddress = 32'h0000_2020;
        iR0ReadValid = 1'b1; iR1ReadValid = 1'b1;
        step();
        checkVal("rd0_valid", oCPLReadValid, 1);
        checkVal("rd0_addr",  oCPLReadAddress, 32'h0000_0010);
        iCPLReadData = 32'hA0A0_0010; iCPLReadAck = 1'b1;
        #1;
        checkVal("rd0_ack",     {oR0ReadAck, oR1ReadAck}, 2'b10);
        checkVal("rd0_data",    oR0ReadData, 32'hA0A0_0010);
        checkVal("rd0_r1_data", oR1ReadData, 0);
        step();
        iCPLReadAck = 1'b0; iR0ReadValid = 1'b0;
        #1;
        checkVal("rd_gap_valid", oCPLReadValid, 0);
        step();
        checkVal("rd1_valid", oCPLReadValid, 1);
        checkVal("rd1_addr",  oCPLReadAddress, 32'h0000_2020);
        iCPLReadData = 32'hB0B0_2020; iCPLReadAck = 1'b1;
        #1;
        checkVal("rd1_ack",  {oR0ReadAck, oR1ReadAck}, 2'b01);
        checkVal("rd1_data", oR1ReadData, 32'hB0B0_2020);
        step();
        iCPLReadAck = 1'b0; iR1ReadValid = 1'b0;
        step();

        // R1 reads ADDR_LIMIT: rejected locally
        iR1ReadAddress = 32'h0000_5000; iR1ReadValid = 1'b1;
        #1;
        checkVal("rej_early_ack", oR1ReadAck, 0);
        step();
        checkVal("rej_no_fwd",   oCPLReadValid, 0);
        checkVal("rej_ack",      oR1ReadAck, 1);
        checkVal("rej_data",     oR1ReadData, 32'hDEAD_BEEF);
        checkVal("rej_err",      {oErrValid, oErrIsRead, oErrRequester}, 3'b111);
        checkVal("rej_err_addr", oErrAddress, 32'h0000_5000);
        iR1ReadValid = 1'b0;
        step();
        checkVal("rej_ack_once", oR1ReadAck, 0);

        // Write and read reject together with a clear: write recorded
        iR0WriteAddress = 32'h6000_0000; iR0WriteValid = 1'b1;
        iR1ReadAddress  = 32'hFFFF_FFFF; iR1ReadValid  = 1'b1;
        iErrClear = 1'b1;
        step();
        iErrClear = 1'b0;
        #1;
        checkVal("dual_err",      {oErrValid, oErrIsRead, oErrRequester}, 3'b100);
        checkVal("dual_err_addr", oErrAddress, 32'h6000_0000);
        checkVal("dual_acks",     {oR0WriteAck, oR1ReadAck}, 2'b11);
        checkVal("dual_rd_data",  oR1ReadData, 32'hDEAD_BEEF);
        checkVal("dual_no_fwd",   {oCPLWriteValid, oCPLReadValid}, 0);
        iR0WriteValid = 1'b0; iR1ReadValid = 1'b0;
        step();
        iErrClear = 1'b1;
        step();
        iErrClear = 1'b0;
        #1;
        checkVal("clr_valid", oErrValid, 0);
        checkVal("clr_addr",  oErrAddress, 0);

        // Fresh pointers, then six back-to-back writes with reads alongside
        iReset = 1'b1;
        step();
        iReset = 1'b0;
        iR0WriteAddress = 32'h0000_0100; iR0WriteData = 32'h5000_0000; iR0WriteValid = 1'b1;
        iR1WriteAddress = 32'h0000_0200; iR1WriteData = 32'h6000_0000; iR1WriteValid = 1'b1;
        iR0ReadAddress  = 32'h0000_4FFF; iR0ReadValid = 1'b1;
        nW = 0; nR = 0; upd0 = 1'b0; upd1 = 1'b0;
        for (int cyc = 0; cyc < 40 && nW < 6; cyc++) begin
            step();
            iCPLWriteAck = 1'b0; iCPLReadAck = 1'b0;
            if (upd0) begin iR0WriteAddress += 4; iR0WriteData += 1; upd0 = 1'b0; end
            if (upd1) begin iR1WriteAddress += 4; iR1WriteData += 1; upd1 = 1'b0; end
            #1;
            wAcked = 1'b0; rAcked = 1'b0;
            if (oCPLWriteValid) begin
                expGrant = (nW % 2 == 1) ? 2'b10 : 2'b01;
                expAddr  = expGrant[1] ? iR1WriteAddress : iR0WriteAddress;
                expData  = expGrant[1] ? iR1WriteData : iR0WriteData;
                checkVal("rr_wr_addr", oCPLWriteAddress, expAddr);
                checkVal("rr_wr_data", oCPLWriteData, expData);
                iCPLWriteAck = 1'b1;
                wAcked = 1'b1;
            end
            if (oCPLReadValid) begin
                checkVal("par_rd_addr", oCPLReadAddress, 32'h0000_4FFF);
                iCPLReadData = 32'hC0DE_0000 + nR;
                iCPLReadAck  = 1'b1;
                rAcked = 1'b1;
            end
            #1;
            if (wAcked) begin
                checkVal("rr_grant", {oR1WriteAck, oR0WriteAck}, expGrant);
                if (expGrant[1]) upd1 = 1'b1; else upd0 = 1'b1;
                nW++;
            end
            if (rAcked) begin
                checkVal("par_rd_data", oR0ReadData, 32'hC0DE_0000 + nR);
                nR++;
            end
        end
        checkVal("rr_count", nW, 6);
        checkVal("par_rd_progress", (nR >= 3) ? 1 : 0, 1);
        step();
        iCPLWriteAck = 1'b0; iCPLReadAck = 1'b0;
        iR0WriteValid = 1'b0; iR1WriteValid = 1'b0; iR0ReadValid = 1'b0;
        step();

        // Move the write pointer to R1, then reset during an R1 forward
        iR0WriteAddress = 32'h0000_1000; iR0WriteValid = 1'b1;
        step();
        iCPLWriteAck = 1'b1;
        #1;
        checkVal("pre_rst_ack", oR0WriteAck, 1);
        step();
        iCPLWriteAck = 1'b0; iR0WriteValid = 1'b0;
        iR1WriteAddress = 32'h0000_2000; iR1WriteValid = 1'b1;
        step();
        checkVal("pre_rst_fwd", oCPLWriteValid, 1);
        iReset = 1'b1;
        step();
        iReset = 1'b0;
        iR0WriteValid = 1'b1;
        #1;
        checkVal("post_rst_valid", oCPLWriteValid, 0);
        checkVal("post_rst_acks",  {oR0WriteAck, oR1WriteAck}, 0);
        step();
        checkVal("post_rst_ptr_r0", oCPLWriteAddress, 32'h0000_1000);
        checkVal("post_rst_noack",  {oR0WriteAck, oR1WriteAck}, 0);
        iCPLWriteAck = 1'b1;
        #1;
        checkVal("post_rst_r0_ack", {oR0WriteAck, oR1WriteAck}, 2'b10);
        step();
        iCPLWriteAck = 1'b0; iR0WriteValid = 1'b0;
        step();
        checkVal("r1_after_rst_addr",  oCPLWriteAddress, 32'h0000_2000);
        checkVal("r1_after_rst_stale", {oR0WriteAck, oR1WriteAck}, 0);
        iCPLWriteAck = 1'b1;
        #1;
        checkVal("r1_after_rst_ack", {oR0WriteAck, oR1WriteAck}, 2'b01);
        step();
        iCPLWriteAck = 1'b0; iR1WriteValid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
